// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide, 17-bit-address system RAM between line
// refills (16 bytes) and data loads/stores (1/2/4 bytes). Each request is
// serialised into byte transfers; data is assembled/scattered little-endian.
// Optional feature macro: MEM_ARB_RR_EN selects round-robin arbitration
// instead of fixed data-over-instruction priority.
module mem_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         inst_re,
  input  logic [31:0]  inst_addr,
  output logic [127:0] inst_data,
  output logic         inst_busy,
  input  logic         data_re,
  input  logic         data_we,
  input  logic [31:0]  data_addr,
  input  logic [1:0]   data_width,
  input  logic [31:0]  data_wdata,
  output logic [31:0]  data_rdata,
  output logic         data_busy,
  output logic [16:0]  mem_a,
  output logic [7:0]   mem_dout,
  input  logic [7:0]   mem_din,
  output logic         mem_wr
);

  localparam int unsigned AW         = 17;
  localparam int unsigned CW         = 5;
  localparam int unsigned LINE_BYTES = 16;

  typedef enum logic [2:0] {IDLE, INST, DREAD, DWRITE, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, len_q, cnt_inc, data_len;
  logic [AW-1:0]  base_q, addr_next, inst_base;
  logic [31:0]    wdata_q;
  logic [127:0]   inst_shadow_q, inst_shadow_nxt;
  logic [31:0]    data_shadow_q, data_shadow_nxt;
  logic [3:0]     inst_lane;
  logic [1:0]     data_lane;
  logic [7:0]     wbyte_next;
  logic           data_req, data_wins;
  logic           grant_data, grant_inst, xfer_last;
  logic           unused_addr_bits;

  assign data_req         = data_re | data_we;
  assign inst_base        = {inst_addr[16:4], 4'h0};
  assign unused_addr_bits = ^{inst_addr[31:17], inst_addr[3:0], data_addr[31:17]};

`ifdef MEM_ARB_RR_EN
  logic last_inst_q;

  // Data wins a tie unless it was the most recent grant.
  assign data_wins = !inst_re || last_inst_q;

  // Remember which requester was granted last; reset favours data.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_inst_q <= 1'b1;
    end else if (rdy) begin
      if (grant_data)      last_inst_q <= 1'b0;
      else if (grant_inst) last_inst_q <= 1'b1;
    end
  end
`else
  assign data_wins = 1'b1;
`endif

  // Byte-count decode, next address and lane insertion for captured bytes.
  always_comb begin
    cnt_inc    = cnt_q + CW'(1);
    addr_next  = base_q + AW'(cnt_inc);
    inst_lane  = 4'(cnt_q - CW'(1));
    data_lane  = 2'(cnt_q - CW'(1));
    wbyte_next = wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
    inst_shadow_nxt = inst_shadow_q;
    inst_shadow_nxt[{inst_lane, 3'b000} +: 8] = mem_din;
    data_shadow_nxt = data_shadow_q;
    data_shadow_nxt[{data_lane, 3'b000} +: 8] = mem_din;
    case (data_width)
      2'b00:   data_len = CW'(1);
      2'b01:   data_len = CW'(2);
      default: data_len = CW'(4);
    endcase
  end

  // State register; rdy=0 freezes the machine.
  always_ff @(posedge clk) begin
    if (rst)      state_q <= IDLE;
    else if (rdy) state_q <= state_d;
  end

  // Next-state logic with grant and completion strobes.
  always_comb begin
    state_d    = state_q;
    grant_data = 1'b0;
    grant_inst = 1'b0;
    xfer_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_req && data_wins) begin
          grant_data = 1'b1;
          state_d    = data_we ? DWRITE : DREAD;
        end else if (inst_re) begin
          grant_inst = 1'b1;
          state_d    = INST;
        end
      end
      INST, DREAD: begin
        if (cnt_q == len_q) begin
          xfer_last = 1'b1;
          state_d   = DONE;
        end
      end
      DWRITE: begin
        if (cnt_q == len_q - CW'(1)) begin
          xfer_last = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transfer datapath: RAM address/strobe sequencing and data assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      len_q         <= '0;
      base_q        <= '0;
      wdata_q       <= '0;
      inst_shadow_q <= '0;
      data_shadow_q <= '0;
      inst_data     <= '0;
      data_rdata    <= '0;
      inst_busy     <= 1'b0;
      data_busy     <= 1'b0;
      mem_a         <= '0;
      mem_dout      <= '0;
      mem_wr        <= 1'b0;
    end else if (rdy) begin
      case (state_q)
        IDLE: begin
          if (grant_data) begin
            cnt_q     <= '0;
            len_q     <= data_len;
            base_q    <= data_addr[AW-1:0];
            wdata_q   <= data_wdata;
            mem_a     <= data_addr[AW-1:0];
            data_busy <= 1'b1;
            if (data_we) begin
              mem_wr   <= 1'b1;
              mem_dout <= data_wdata[7:0];
            end else begin
              data_shadow_q <= '0;
            end
          end else if (grant_inst) begin
            cnt_q         <= '0;
            len_q         <= CW'(LINE_BYTES);
            base_q        <= inst_base;
            mem_a         <= inst_base;
            inst_shadow_q <= '0;
            inst_busy     <= 1'b1;
          end
        end
        INST: begin
          cnt_q <= cnt_inc;
          if (cnt_inc < len_q) mem_a <= addr_next;
          if (cnt_q != '0)     inst_shadow_q <= inst_shadow_nxt;
          if (xfer_last) begin
            inst_data <= inst_shadow_nxt;
            inst_busy <= 1'b0;
          end
        end
        DREAD: begin
          cnt_q <= cnt_inc;
          if (cnt_inc < len_q) mem_a <= addr_next;
          if (cnt_q != '0)     data_shadow_q <= data_shadow_nxt;
          if (xfer_last) begin
            data_rdata <= data_shadow_nxt;
            data_busy  <= 1'b0;
          end
        end
        DWRITE: begin
          cnt_q <= cnt_inc;
          if (xfer_last) begin
            mem_wr    <= 1'b0;
            data_busy <= 1'b0;
          end else begin
            mem_a    <= addr_next;
            mem_dout <= wbyte_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
